// File: rtl/run_pkg.sv
// Shared types and constants for the run-length expander.
package run_pkg;
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {IDLE, EXPAND, FLUSH} state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic [CNT_W-1:0]  nbits;
    logic [CNT_W-1:0]  num1;
    logic [CNT_W-1:0]  num0;
  } out_t;
endpackage

// File: rtl/byte_popcnt.sv
// Counts ones and zeros over the low nbits of a byte.
module byte_popcnt
  import run_pkg::*;
(
  input  logic [BYTE_W-1:0] data,
  input  logic [CNT_W-1:0]  nbits,
  output logic [CNT_W-1:0]  num1,
  output logic [CNT_W-1:0]  num0
);
  always_comb begin
    num1 = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      if (CNT_W'(i) < nbits) num1 = num1 + CNT_W'(data[i]);
    end
  end

  assign num0 = nbits - num1;
endmodule

// File: rtl/run_expander.sv
// Expands (bit, length) run tokens into LSB-first packed bytes with bit counts.
// state  | meaning
// IDLE   | ready for a token or a flush request
// EXPAND | writing the latched bit, one per cycle
// FLUSH  | waiting to emit the partial byte
module run_expander
  import run_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run_valid,
  output logic              run_ready,
  input  logic              run_bit,
  input  logic [LEN_W-1:0]  run_len,
  input  logic              flush,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_data,
  output logic [CNT_W-1:0]  byte_nbits,
  output logic [CNT_W-1:0]  byte_num1,
  output logic [CNT_W-1:0]  byte_num0,
  output logic              err_len
);
  state_t            state;
  logic [BYTE_W-1:0] acc;
  logic [IDX_W-1:0]  idx;
  logic [LEN_W-1:0]  rem;
  logic              bit_q;
  out_t              out_q;
  out_t              load_out;
  logic              out_free;

  assign out_free = !byte_valid || byte_ready;

  // Flush masks stale bits above idx; a completing write merges the final bit.
  always_comb begin
    if (state == FLUSH) begin
      load_out.data  = acc & ~({BYTE_W{1'b1}} << idx);
      load_out.nbits = CNT_W'(idx);
    end else begin
      load_out.data  = {bit_q, acc[BYTE_W-2:0]};
      load_out.nbits = CNT_W'(BYTE_W);
    end
  end

  byte_popcnt u_popcnt (
    .data  (load_out.data),
    .nbits (load_out.nbits),
    .num1  (load_out.num1),
    .num0  (load_out.num0)
  );

  assign byte_data  = out_q.data;
  assign byte_nbits = out_q.nbits;
  assign byte_num1  = out_q.num1;
  assign byte_num0  = out_q.num0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      run_ready  <= 1'b1;
      acc        <= '0;
      idx        <= '0;
      rem        <= '0;
      bit_q      <= 1'b0;
      out_q      <= '0;
      byte_valid <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      err_len <= 1'b0;
      if (byte_valid && byte_ready) byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run_valid) begin
            if (run_len == '0) begin
              err_len <= 1'b1;
            end else begin
              bit_q     <= run_bit;
              rem       <= run_len;
              state     <= EXPAND;
              run_ready <= 1'b0;
            end
          end else if (flush && idx != '0) begin
            state     <= FLUSH;
            run_ready <= 1'b0;
          end
        end
        EXPAND: begin
          // The byte-completing write waits for the output register to free.
          if (idx != IDX_W'(BYTE_W - 1) || out_free) begin
            acc[idx] <= bit_q;
            idx      <= idx + IDX_W'(1);
            rem      <= rem - LEN_W'(1);
            if (idx == IDX_W'(BYTE_W - 1)) begin
              out_q      <= load_out;
              byte_valid <= 1'b1;
            end
            if (rem == LEN_W'(1)) begin
              state     <= IDLE;
              run_ready <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            out_q      <= load_out;
            byte_valid <= 1'b1;
            idx        <= '0;
            state      <= IDLE;
            run_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          run_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_run_expander.sv
// Self-checking bench for run_expander: vector table, scoreboard and corner sequences.
module tb_run_expander;
  logic       clk = 1'b0;
  logic       rst, run_valid, run_ready, run_bit, flush;
  logic       byte_valid, byte_ready, err_len;
  logic [3:0] run_len, byte_nbits, byte_num1, byte_num0;
  logic [7:0] byte_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] nb;
    logic [3:0] n1;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  typedef struct {
    logic       b0;
    int         l0;
    logic       b1;
    int         l1;
    logic       fl;
    logic [7:0] d;
    int         nb;
    int         n1;
  } vec_t;
  vec_t vt[8];

  run_expander dut (
    .clk(clk), .rst(rst), .run_valid(run_valid), .run_ready(run_ready),
    .run_bit(run_bit), .run_len(run_len), .flush(flush),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_nbits(byte_nbits), .byte_num1(byte_num1), .byte_num0(byte_num0),
    .err_len(err_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input int nb, input int n1);
    sb.push_back({d, 4'(nb), 4'(n1)});
  endtask

  // Scoreboard consumer: every handshaked byte is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=0x%0h required=none", byte_data);
      end else begin
        e = sb.pop_front();
        chk("byte", int'({byte_data, byte_nbits, byte_num1, byte_num0}),
            int'({e.d, e.nb, e.n1, 4'(e.nb - e.n1)}));
      end
    end
  end

  task automatic send_token(input logic b, input int len, output int acc_cyc);
    @(posedge clk); #1;
    run_valid = 1'b1; run_bit = b; run_len = 4'(len); acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (run_ready) begin acc_cyc = cyc; break; end
    end
    if (acc_cyc < 0) chk("token_timeout", 0, 1);
    @(posedge clk); #1;
    run_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (run_ready) begin ok = 1; break; end
    end
    if (ok == 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_flush();
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int a, rise, bad;
    vt[0] = '{1'b1, 3, 1'b0, 5, 1'b0, 8'h07, 8, 3};
    vt[1] = '{1'b0, 2, 1'b1, 6, 1'b0, 8'hFC, 8, 6};
    vt[2] = '{1'b1, 1, 1'b0, 1, 1'b1, 8'h01, 2, 1};
    vt[3] = '{1'b1, 4, 1'b1, 3, 1'b1, 8'h7F, 7, 7};
    vt[4] = '{1'b0, 3, 1'b1, 2, 1'b1, 8'h18, 5, 2};
    vt[5] = '{1'b1, 5, 1'b0, 3, 1'b0, 8'h1F, 8, 5};
    vt[6] = '{1'b0, 7, 1'b1, 1, 1'b0, 8'h80, 8, 1};
    vt[7] = '{1'b1, 3, 1'b0, 0, 1'b1, 8'h07, 3, 3};

    rst = 1'b1; run_valid = 1'b0; run_bit = 1'b0; run_len = '0;
    flush = 1'b0; byte_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_run_ready", run_ready, 1);
    chk("reset_outputs", int'({byte_valid, err_len, byte_data, byte_nbits, byte_num1, byte_num0}), 0);
    @(posedge clk); #1; rst = 1'b0;

    // Latency: byte_valid six cycles after the completing token is accepted.
    push_exp(8'h07, 8, 3);
    send_token(1'b1, 3, a);
    send_token(1'b0, 5, a);
    rise = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (byte_valid) begin rise = cyc; break; end
    end
    chk("latency", rise - a, 6);
    drain();

    for (int v = 0; v < 8; v++) begin
      push_exp(vt[v].d, vt[v].nb, vt[v].n1);
      send_token(vt[v].b0, vt[v].l0, a);
      if (vt[v].l1 != 0) send_token(vt[v].b1, vt[v].l1, a);
      wait_idle();
      if (vt[v].fl) begin do_flush(); wait_idle(); end
      drain();
    end

    // Spill across a byte boundary.
    push_exp(8'hFF, 8, 8);
    push_exp(8'h0F, 8, 4);
    send_token(1'b1, 12, a);
    send_token(1'b0, 4, a);
    wait_idle();
    drain();

    // Back-pressure: second run stalls on its byte-completing bit.
    byte_ready = 1'b0;
    push_exp(8'h00, 8, 0);
    push_exp(8'hFF, 8, 8);
    send_token(1'b0, 8, a);
    send_token(1'b1, 8, a);
    repeat (12) @(negedge clk);
    chk("stall_valid", byte_valid, 1);
    chk("stall_data_held", byte_data, 8'h00);
    chk("stall_run_ready", run_ready, 0);
    @(posedge clk); #1; byte_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_valid", byte_valid, 1);
    chk("b2b_data", byte_data, 8'hFF);
    drain();
    wait_idle();

    // Zero-length token.
    send_token(1'b1, 0, a);
    @(negedge clk);
    chk("err_len_pulse", err_len, 1);
    @(negedge clk);
    chk("err_len_clear", err_len, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (byte_valid) bad = 1;
    end
    chk("err_no_byte", bad, 0);

    // Reset with a held byte and a partial byte in flight.
    byte_ready = 1'b0;
    send_token(1'b1, 8, a);
    wait_idle();
    send_token(1'b0, 5, a);
    @(posedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_run_ready", run_ready, 1);
    chk("midrst_outputs", int'({byte_valid, err_len, byte_data, byte_nbits, byte_num1, byte_num0}), 0);
    @(posedge clk); #1; rst = 1'b0; byte_ready = 1'b1;
    push_exp(8'hFF, 8, 8);
    send_token(1'b1, 8, a);
    wait_idle();
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
